// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write side.
package rf_pkg;
  localparam int XLEN       = 32;
  localparam int REG_AW     = 5;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; head is always visible on o_dout.
module wb_fifo
  import rf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  wb_req_t       i_din,
  output wb_req_t       o_dout,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage is not reset; only pointers and occupancy carry meaning.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges pipeline and long-latency writebacks onto the single rf write port,
// tracks pending long-latency destinations and forces a drain when the queue starves.
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter  int DEPTH      = rf_pkg::DEPTH,
  parameter  int STARVE_MAX = rf_pkg::STARVE_MAX,
  localparam int CW         = $clog2(DEPTH) + 1,
  localparam int AGE_W      = $clog2(STARVE_MAX) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wr_en,
  input  logic [REG_AW-1:0] pipe_waddr,
  input  logic [XLEN-1:0]   pipe_wdata,
  input  logic              ll_issue,
  input  logic [REG_AW-1:0] ll_issue_rd,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [REG_AW-1:0] ll_waddr,
  input  logic [XLEN-1:0]   ll_wdata,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              wb_stall,
  output logic              rf_en,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [CW-1:0]     ll_count
);
  // Handshake: a result transfers on any posedge where ll_valid & ll_ready;
  // ll_valid must then hold its payload until accepted.
  wb_req_t         w_head;
  wb_req_t         w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [31:0]     w_pending_nxt;
  logic [31:0]     r_pending;
  logic [AGE_W-1:0] r_age;
  logic            r_wb_stall;

  assign w_push_req = '{addr: ll_waddr, data: ll_wdata};
  assign ll_ready   = rst_n & ~w_full;
  assign w_push     = ll_valid & ll_ready & (ll_waddr != '0);
  assign w_pop      = rst_n & ~pipe_wr_en & ~w_empty;
  assign ll_count   = rst_n ? w_count : '0;
  assign wb_stall   = r_wb_stall;
  assign rs1_busy   = rst_n & r_pending[rs1] & (rs1 != '0);
  assign rs2_busy   = rst_n & r_pending[rs2] & (rs2 != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_req),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    if (pipe_wr_en) begin
      rf_waddr = pipe_waddr;
      rf_wdata = pipe_wdata;
    end else if (!w_empty) begin
      rf_waddr = w_head.addr;
      rf_wdata = w_head.data;
    end
    rf_en = rst_n & (pipe_wr_en | ~w_empty) & (rf_waddr != '0);
  end

  // A new issue to the register being retired this cycle must stay pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head.addr] = 1'b0;
    if (ll_issue && (ll_issue_rd != '0)) w_pending_nxt[ll_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_age      <= '0;
      r_wb_stall <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_pop || w_empty) r_age <= '0;
      else if (r_age != AGE_W'(STARVE_MAX - 1)) r_age <= r_age + AGE_W'(1);
      if (w_pop) r_wb_stall <= 1'b0;
      else if (!w_empty && (r_age == AGE_W'(STARVE_MAX - 1))) r_wb_stall <= 1'b1;
    end
  end

  a_issue_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (ll_issue && ll_issue_rd != '0) |->
      (!r_pending[ll_issue_rd] || (w_pop && w_head.addr == ll_issue_rd)));
  a_pipe_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (pipe_wr_en && pipe_waddr != '0) |-> !r_pending[pipe_waddr]);
  a_pipe_stall: assert property (@(posedge clk) disable iff (!rst_n)
    pipe_wr_en |-> !r_wb_stall);
  a_ll_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (ll_valid && ll_waddr != '0) |-> r_pending[ll_waddr]);
endmodule
